// File: rtl/dvp_timing_lock.sv
// dvp_timing_lock
//   DVP video-timing lock monitor in the DVP pixel-clock domain. It measures
//   DE run lengths and DE runs per VSYNC-delimited frame, and runs a lock FSM:
//     SEARCH -> ACQUIRE -> LOCKED <-> HOLD.
//   Lock is declared after LOCK_FRAMES consecutive good frames. Isolated bad
//   frames are tolerated in HOLD. Lock drops after LOSS_FRAMES bad frames, or
//   when the VSYNC watchdog expires. It also drives a frame-rate LED blink.
//
//   Optional feature macro: DVP_LOCK_STATS_EN
//     defined   : line_len, line_count and err_frames carry statistics
//     undefined : those ports are tied to 0 and their capture logic is absent
//
// Ports
//   clk         in   DVP pixel clock
//   rst         in   asynchronous active-high reset
//   vsync       in   DVP VSYNC, rising edge starts a frame
//   de          in   DVP data enable
//   locked      out  high in LOCKED or HOLD
//   state       out  SEARCH=0, ACQUIRE=1, LOCKED=2, HOLD=3
//   lost        out  one-cycle pulse on LOCKED/HOLD -> SEARCH
//   frame_pulse out  one-cycle pulse per VSYNC rising edge
//   blink       out  frame-rate LED, 0 unless locked
//   line_len    out  last completed DE run length
//   line_count  out  DE runs in the last evaluated frame
//   err_frames  out  saturating count of bad frames seen while locked
module dvp_timing_lock #(
   parameter int H_ACTIVE     = 1280,
   parameter int V_ACTIVE     = 720,
   parameter int LOCK_FRAMES  = 4,
   parameter int LOSS_FRAMES  = 2,
   parameter int BLINK_FRAMES = 60,
   parameter int WDOG_CYCLES  = 2_000_000,
   parameter int HCNT_W       = 12,
   parameter int VCNT_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              de,
   output logic              locked,
   output logic [1:0]        state,
   output logic              lost,
   output logic              frame_pulse,
   output logic              blink,
   output logic [HCNT_W-1:0] line_len,
   output logic [VCNT_W-1:0] line_count,
   output logic [15:0]       err_frames
);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2,
      S_HOLD    = 2'd3
   } state_t;

   localparam int GC_W = $clog2(LOCK_FRAMES + 1);
   localparam int BC_W = $clog2(LOSS_FRAMES + 1);
   localparam int BL_W = $clog2(BLINK_FRAMES + 1);
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   localparam logic [HCNT_W-1:0] H_TGT     = HCNT_W'(H_ACTIVE);
   localparam logic [VCNT_W-1:0] V_TGT     = VCNT_W'(V_ACTIVE);
   localparam logic [GC_W-1:0]   LOCK_LAST = GC_W'(LOCK_FRAMES - 1);
   localparam logic [BC_W-1:0]   LOSS_LAST = BC_W'(LOSS_FRAMES - 1);
   localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(BLINK_FRAMES - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(WDOG_CYCLES - 1);

   state_t            state_q;
   logic [GC_W-1:0]   good_cnt_q;
   logic [BC_W-1:0]   bad_cnt_q;
   logic              lost_q;
   logic              vsync_q, de_q;
   logic [HCNT_W-1:0] run_q;
   logic [VCNT_W-1:0] line_q, line_d;
   logic              frame_bad_q, bad_d;
   logic              seen_q;
   logic [WD_W-1:0]   wdog_q;
   logic [BL_W-1:0]   blink_cnt_q;
   logic              blink_q;
   logic              frame_pulse_q;
   logic              vs_edge, de_fall, frame_good, wd_expire;

   // A DE fall in the same cycle as a VSYNC edge belongs to the closing frame,
   // so the evaluation uses the line/bad values including this cycle's fall.
   always_comb begin
      vs_edge = vsync & ~vsync_q;
      de_fall = ~de & de_q;
      line_d  = line_q;
      bad_d   = frame_bad_q;
      if (de_fall) begin
         if (run_q != H_TGT) bad_d = 1'b1;
         if (&line_q) bad_d = 1'b1;
         else         line_d = line_q + 1'b1;
      end
      frame_good = seen_q & ~bad_d & (line_d == V_TGT);
      wd_expire  = state_q[1] & (wdog_q == WD_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_q       <= 1'b0;
         de_q          <= 1'b0;
         run_q         <= '0;
         line_q        <= '0;
         frame_bad_q   <= 1'b0;
         seen_q        <= 1'b0;
         wdog_q        <= '0;
         blink_cnt_q   <= '0;
         blink_q       <= 1'b0;
         frame_pulse_q <= 1'b0;
      end else begin
         vsync_q       <= vsync;
         de_q          <= de;
         frame_pulse_q <= vs_edge;
         if (de) begin
            if (!(&run_q)) run_q <= run_q + 1'b1;
         end else begin
            run_q <= '0;
         end
         if (vs_edge || wd_expire) begin
            line_q      <= '0;
            frame_bad_q <= 1'b0;
         end else begin
            line_q      <= line_d;
            frame_bad_q <= bad_d;
         end
         // A coincident edge is the first edge of the new search, so it
         // still marks VSYNC as seen; a bare expiry forgets it.
         if (vs_edge)        seen_q <= 1'b1;
         else if (wd_expire) seen_q <= 1'b0;
         if (vs_edge || wd_expire || !state_q[1]) wdog_q <= '0;
         else                                     wdog_q <= wdog_q + 1'b1;
         if (vs_edge) begin
            if (blink_cnt_q == BL_LAST) begin
               blink_cnt_q <= '0;
               blink_q     <= ~blink_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end
      end
   end

   // Lock FSM: advances only on VSYNC edges, except for the watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_SEARCH;
         good_cnt_q <= '0;
         bad_cnt_q  <= '0;
         lost_q     <= 1'b0;
      end else begin
         lost_q <= 1'b0;
         if (wd_expire) begin
            state_q    <= S_SEARCH;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            lost_q     <= 1'b1;
         end else if (vs_edge) begin
            case (state_q)
               S_SEARCH: begin
                  if (frame_good) begin
                     if (LOCK_FRAMES == 1) begin
                        state_q <= S_LOCKED;
                     end else begin
                        state_q    <= S_ACQUIRE;
                        good_cnt_q <= GC_W'(1);
                     end
                  end
               end
               S_ACQUIRE: begin
                  if (!frame_good) begin
                     state_q    <= S_SEARCH;
                     good_cnt_q <= '0;
                  end else if (good_cnt_q == LOCK_LAST) begin
                     state_q    <= S_LOCKED;
                     good_cnt_q <= '0;
                  end else begin
                     good_cnt_q <= good_cnt_q + 1'b1;
                  end
               end
               S_LOCKED: begin
                  if (!frame_good) begin
                     if (LOSS_FRAMES == 1) begin
                        state_q <= S_SEARCH;
                        lost_q  <= 1'b1;
                     end else begin
                        state_q   <= S_HOLD;
                        bad_cnt_q <= BC_W'(1);
                     end
                  end
               end
               default: begin
                  if (frame_good) begin
                     state_q   <= S_LOCKED;
                     bad_cnt_q <= '0;
                  end else if (bad_cnt_q == LOSS_LAST) begin
                     state_q   <= S_SEARCH;
                     bad_cnt_q <= '0;
                     lost_q    <= 1'b1;
                  end else begin
                     bad_cnt_q <= bad_cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign state       = state_q;
   assign locked      = state_q[1];
   assign lost        = lost_q;
   assign frame_pulse = frame_pulse_q;
   assign blink       = blink_q & state_q[1];

`ifdef DVP_LOCK_STATS_EN
   logic [HCNT_W-1:0] line_len_q;
   logic [VCNT_W-1:0] line_count_q;
   logic [15:0]       err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_len_q   <= '0;
         line_count_q <= '0;
         err_q        <= '0;
      end else begin
         if (de_fall) line_len_q <= run_q;
         if (vs_edge) line_count_q <= line_d;
         // Only real evaluations in LOCKED/HOLD count; an expiring watchdog
         // turns a coincident edge into a SEARCH evaluation.
         if (vs_edge && !wd_expire && state_q[1] && !frame_good && !(&err_q))
            err_q <= err_q + 1'b1;
      end
   end

   assign line_len   = line_len_q;
   assign line_count = line_count_q;
   assign err_frames = err_q;
`else
   assign line_len   = '0;
   assign line_count = '0;
   assign err_frames = '0;
`endif

endmodule
